// File: rtl/writeback_stage_pkg.sv
// rtl/writeback_stage_pkg.sv - shared encodings and defaults for the writeback stage
package writeback_stage_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  // Byte-offset width inside one XLEN-wide load beat.
  function automatic int off_width(input int xlen);
    return (xlen == 64) ? 3 : 2;
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - MEM->WB input bundle plus register-file/forwarding outputs
interface writeback_stage_if
  import writeback_stage_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int REG_ADDR_W = 5
);

  logic                  in_valid;
  logic                  in_ready;
  logic                  stall;
  logic                  flush;
  logic                  reg_write_in;
  logic [1:0]            result_src_in;
  logic [2:0]            load_fmt_in;
  logic [REG_ADDR_W-1:0] rd_in;
  logic [XLEN-1:0]       pc_plus4_in;
  logic [XLEN-1:0]       alu_result_in;
  logic [XLEN-1:0]       imm_in;
  logic [XLEN-1:0]       read_data_in;

  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [XLEN-1:0]       wb_data;
  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_addr;
  logic [XLEN-1:0]       fwd_data;
  logic                  retired;

  modport slave (
    input  in_valid, stall, flush, reg_write_in, result_src_in, load_fmt_in, rd_in,
           pc_plus4_in, alu_result_in, imm_in, read_data_in,
    output in_ready, wb_en, wb_addr, wb_data, fwd_valid, fwd_addr, fwd_data, retired
  );

  modport master (
    output in_valid, stall, flush, reg_write_in, result_src_in, load_fmt_in, rd_in,
           pc_plus4_in, alu_result_in, imm_in, read_data_in,
    input  in_ready, wb_en, wb_addr, wb_data, fwd_valid, fwd_addr, fwd_data, retired
  );

endinterface

// File: rtl/writeback_stage_load_align.sv
// rtl/writeback_stage_load_align.sv - combinational load byte/half/word select and extend
module load_align
  import writeback_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0]              raw,
  input  logic [off_width(XLEN)-1:0]   off,
  input  logic [2:0]                   fmt,
  output logic [XLEN-1:0]              aligned
);

  localparam int OW = off_width(XLEN);

  logic [OW-1:0]   half_off;
  logic [7:0]      b;
  logic [15:0]     h;
  logic [XLEN-1:0] word_sx;
  logic [XLEN-1:0] word_zx;

  // Halfword select ignores off[0]; misalignment is not trapped here.
  assign half_off = {off[OW-1:1], 1'b0};
  assign b        = 8'(raw >> {off, 3'b000});
  assign h        = 16'(raw >> {half_off, 3'b000});

  generate
    if (XLEN == 64) begin : g_rv64
      logic [31:0] w;
      assign w       = 32'(raw >> {off[OW-1], 5'b00000});
      assign word_sx = {{(XLEN-32){w[31]}}, w};
      assign word_zx = {{(XLEN-32){1'b0}}, w};
    end else begin : g_rv32
      assign word_sx = raw;
      assign word_zx = raw;
    end
  endgenerate

  always_comb begin
    aligned = word_sx;
    case (fmt)
      LB:      aligned = {{(XLEN-8){b[7]}}, b};
      LBU:     aligned = {{(XLEN-8){1'b0}}, b};
      LH:      aligned = {{(XLEN-16){h[15]}}, h};
      LHU:     aligned = {{(XLEN-16){1'b0}}, h};
      LD:      aligned = raw;
      LWU:     aligned = word_zx;
      default: aligned = word_sx;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB register, result select, regfile/forward drive, retire strobe
// Optional instret counter enabled by WB_INSTRET_EN.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int REG_ADDR_W = 5
`ifdef WB_INSTRET_EN
  , parameter int CNT_W    = 64
`endif
) (
  input logic clk,
  input logic rst,
  writeback_stage_if.slave bus
`ifdef WB_INSTRET_EN
  , output logic [CNT_W-1:0] instret
`endif
);

  localparam int OW = off_width(XLEN);

  logic                  valid_q;
  logic                  reg_write_q;
  result_src_e           result_src_q;
  logic [2:0]            load_fmt_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       pc_plus4_q;
  logic [XLEN-1:0]       alu_result_q;
  logic [XLEN-1:0]       imm_q;
  logic [XLEN-1:0]       read_data_q;

  logic [XLEN-1:0]       load_data;
  logic [XLEN-1:0]       result;
  logic                  wb_en_int;
  logic                  retired_int;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      result_src_q <= RES_ALU;
      load_fmt_q   <= 3'b000;
      rd_q         <= '0;
      pc_plus4_q   <= '0;
      alu_result_q <= '0;
      imm_q        <= '0;
      read_data_q  <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (!bus.stall) begin
      valid_q      <= bus.in_valid;
      reg_write_q  <= bus.reg_write_in;
      result_src_q <= result_src_e'(bus.result_src_in);
      load_fmt_q   <= bus.load_fmt_in;
      rd_q         <= bus.rd_in;
      pc_plus4_q   <= bus.pc_plus4_in;
      alu_result_q <= bus.alu_result_in;
      imm_q        <= bus.imm_in;
      read_data_q  <= bus.read_data_in;
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .raw     (read_data_q),
    .off     (alu_result_q[OW-1:0]),
    .fmt     (load_fmt_q),
    .aligned (load_data)
  );

  always_comb begin
    result = alu_result_q;
    case (result_src_q)
      RES_MEM: result = load_data;
      RES_PC4: result = pc_plus4_q;
      RES_IMM: result = imm_q;
      default: result = alu_result_q;
    endcase
  end

  // A stalled instruction keeps writing the same value; it retires only when released.
  assign wb_en_int   = valid_q & reg_write_q & (rd_q != '0);
  assign retired_int = valid_q & ~bus.stall;

  assign bus.in_ready  = ~bus.stall;
  assign bus.wb_en     = wb_en_int;
  assign bus.wb_addr   = rd_q;
  assign bus.wb_data   = result;
  assign bus.fwd_valid = wb_en_int;
  assign bus.fwd_addr  = rd_q;
  assign bus.fwd_data  = result;
  assign bus.retired   = retired_int;

`ifdef WB_INSTRET_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret <= '0;
    end else if (retired_int) begin
      instret <= instret + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - scoreboard bench for writeback_stage (XLEN=32)
module tb_writeback_stage;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   n_retire = 0;
  exp_t exp_q[$];

  writeback_stage_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

`ifdef WB_INSTRET_EN
  logic [3:0] instret;
  writeback_stage #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .instret(instret)
  );
`else
  writeback_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic set_txn(input logic rw, input logic [1:0] src, input logic [2:0] fmt,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] opnd,
                         input logic [31:0] exp_data, input bit push);
    exp_t e;
    bus.in_valid      = 1'b1;
    bus.reg_write_in  = rw;
    bus.result_src_in = src;
    bus.load_fmt_in   = fmt;
    bus.rd_in         = rd;
    bus.alu_result_in = alu;
    bus.pc_plus4_in   = opnd;
    bus.imm_in        = opnd;
    bus.read_data_in  = opnd;
    if (push) begin
      e.en   = rw && (rd != 5'd0);
      e.addr = rd;
      e.data = exp_data;
      exp_q.push_back(e);
      n_retire++;
    end
  endtask

  task automatic issue(input logic rw, input logic [1:0] src, input logic [2:0] fmt,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] opnd,
                       input logic [31:0] exp_data, input bit push);
    @(posedge clk); #1;
    set_txn(rw, src, fmt, rd, alu, opnd, exp_data, push);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Monitor: every retire pulse consumes one expected instruction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.retired === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: got retire with wb_addr=%0d, expected none", bus.wb_addr);
        end else begin
          e = exp_q.pop_front();
          chk("ret_wb_en", 64'(bus.wb_en), 64'(e.en));
          chk("ret_fwd_valid", 64'(bus.fwd_valid), 64'(e.en));
          chk("ret_in_ready", 64'(bus.in_ready), 64'd1);
          if (e.en) begin
            chk("ret_wb_addr", 64'(bus.wb_addr), 64'(e.addr));
            chk("ret_wb_data", 64'(bus.wb_data), 64'(e.data));
            chk("ret_fwd_addr", 64'(bus.fwd_addr), 64'(e.addr));
            chk("ret_fwd_data", 64'(bus.fwd_data), 64'(e.data));
          end
        end
      end
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: got no finish, expected finish within 5000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.reg_write_in = 1'b0; bus.result_src_in = 2'b00; bus.load_fmt_in = 3'b000;
    bus.rd_in = 5'd0; bus.pc_plus4_in = '0; bus.alu_result_in = '0;
    bus.imm_in = '0; bus.read_data_in = '0;

    #2;
    chk("rst_wb_en", 64'(bus.wb_en), 64'd0);
    chk("rst_fwd_valid", 64'(bus.fwd_valid), 64'd0);
    chk("rst_retired", 64'(bus.retired), 64'd0);
    chk("rst_wb_data", 64'(bus.wb_data), 64'd0);
    chk("rst_wb_addr", 64'(bus.wb_addr), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // ALU, then loads from 0x80FF7F01
    issue(1, 2'b00, 3'b000, 5'd5, 32'h0000_1234, 32'h0, 32'h0000_1234, 1);
    issue(1, 2'b01, 3'b000, 5'd6, 32'h0000_1003, 32'h80FF_7F01, 32'hFFFF_FF80, 1);
    issue(1, 2'b01, 3'b100, 5'd7, 32'h0000_1001, 32'h80FF_7F01, 32'h0000_007F, 1);
    issue(1, 2'b01, 3'b001, 5'd8, 32'h0000_1002, 32'h80FF_7F01, 32'hFFFF_80FF, 1);
    issue(1, 2'b01, 3'b101, 5'd9, 32'h0000_1000, 32'h80FF_7F01, 32'h0000_7F01, 1);
    issue(1, 2'b01, 3'b010, 5'd10, 32'h0000_1000, 32'h80FF_7F01, 32'h80FF_7F01, 1);
    issue(1, 2'b01, 3'b001, 5'd11, 32'h0000_1003, 32'h80FF_7F01, 32'hFFFF_80FF, 1);
    issue(1, 2'b01, 3'b100, 5'd12, 32'h0000_1003, 32'h80FF_7F01, 32'h0000_0080, 1);
    issue(1, 2'b01, 3'b000, 5'd13, 32'h0000_1002, 32'h80FF_7F01, 32'hFFFF_FFFF, 1);
    issue(1, 2'b01, 3'b101, 5'd14, 32'h0000_1002, 32'h80FF_7F01, 32'h0000_80FF, 1);
    issue(1, 2'b01, 3'b011, 5'd15, 32'h0000_1000, 32'h80FF_7F01, 32'h80FF_7F01, 1);
    // x0, PC+4, IMM, no-write
    issue(1, 2'b00, 3'b000, 5'd0, 32'h0000_0042, 32'h0, 32'h0000_0042, 1);
    issue(1, 2'b10, 3'b000, 5'd16, 32'h0000_0000, 32'h0000_0104, 32'h0000_0104, 1);
    issue(1, 2'b11, 3'b000, 5'd17, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
    issue(0, 2'b00, 3'b000, 5'd18, 32'h0000_0077, 32'h0, 32'h0000_0077, 1);

    // Three-cycle stall holding instruction A while B waits at the input
    issue(1, 2'b00, 3'b000, 5'd9, 32'h0000_AAAA, 32'h0, 32'h0000_AAAA, 1);
    @(posedge clk); #1;
    bus.stall = 1'b1;
    set_txn(1, 2'b00, 3'b000, 5'd19, 32'h0000_BBBB, 32'h0, 32'h0000_BBBB, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_retired", 64'(bus.retired), 64'd0);
      chk("stall_wb_en", 64'(bus.wb_en), 64'd1);
      chk("stall_wb_addr", 64'(bus.wb_addr), 64'd9);
      chk("stall_wb_data", 64'(bus.wb_data), 64'h0000_AAAA);
      @(posedge clk); #1;
    end
    bus.stall = 1'b0;
    idle();

    // Flush together with stall kills C without a retire pulse
    issue(1, 2'b00, 3'b000, 5'd20, 32'h0000_CCCC, 32'h0, 32'h0, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.stall = 1'b1; bus.flush = 1'b1;
    #1 chk("flush_stall_retired", 64'(bus.retired), 64'd0);
    @(posedge clk); #1;
    bus.stall = 1'b0; bus.flush = 1'b0;
    #1;
    chk("flushed_wb_en", 64'(bus.wb_en), 64'd0);
    chk("flushed_retired", 64'(bus.retired), 64'd0);

    // Flush without stall: D in WB retires, incoming E is dropped
    issue(1, 2'b00, 3'b000, 5'd21, 32'h0000_DDDD, 32'h0, 32'h0000_DDDD, 1);
    @(posedge clk); #1;
    bus.flush = 1'b1;
    set_txn(1, 2'b00, 3'b000, 5'd22, 32'h0000_EEEE, 32'h0, 32'h0, 0);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    #1;
    chk("flush_drop_wb_en", 64'(bus.wb_en), 64'd0);
    chk("flush_drop_retired", 64'(bus.retired), 64'd0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
`ifdef WB_INSTRET_EN
    chk("instret_wrap", 64'(instret), 64'(n_retire % 16));
`endif

    // Asynchronous reset while an instruction is stalled in WB
    issue(1, 2'b00, 3'b000, 5'd3, 32'h0000_F00F, 32'h0, 32'h0, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.stall = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_wb_en", 64'(bus.wb_en), 64'd0);
    chk("midrst_retired", 64'(bus.retired), 64'd0);
    chk("midrst_wb_data", 64'(bus.wb_data), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus.stall = 1'b0;
    n_retire = 0;
`ifdef WB_INSTRET_EN
    chk("instret_reset", 64'(instret), 64'd0);
`endif
    issue(1, 2'b00, 3'b000, 5'd4, 32'h0000_0055, 32'h0, 32'h0000_0055, 1);
    idle();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    chk("final_queue_drained", 64'(exp_q.size()), 64'd0);
`ifdef WB_INSTRET_EN
    chk("instret_after_reset", 64'(instret), 64'(n_retire % 16));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
